// File: rtl/lsq_load_port_pkg.sv
// Shared LSQ port definitions: default widths, per-cycle event bundle and a
// constant-foldable clog2 used to size counters and pointers.
package lsq_load_port_pkg;

  localparam int unsigned LsqDataSize = 32;
  localparam int unsigned LsqAddrSize = 32;

  // Everything that can happen to the load port in one clock cycle.
  typedef struct packed {
    logic fire;
    logic ret;
    logic spurious;
    logic pop;
  } lsq_evt_t;

  // Ceiling log2; lsq_clog2(1) == 0.
  function automatic int unsigned lsq_clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lsq_load_port_data_fifo.sv
// Depth x DataWidth circular buffer for returned load data. Depth need not be
// a power of two: pointers wrap by explicit compare against the last slot.
module lsq_load_port_data_fifo
  import lsq_load_port_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = LsqDataSize,
  parameter int unsigned CntWidth  = lsq_clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 rd_en_i,
  output logic [DataWidth-1:0] rd_data_o,
  output logic [CntWidth-1:0]  count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? lsq_clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_en_i) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CntWidth'(Depth));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/lsq_load_port.sv
// Memory-side stage for one LSQ load: issues addresses under a credit limit,
// buffers in-order returns and hands them back with valid/ready.
module lsq_load_port
  import lsq_load_port_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = LsqDataSize,
  parameter int unsigned ADDRESS_SIZE = LsqAddrSize,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CNT_W        = lsq_clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDRESS_SIZE-1:0] addr_in,
  input  logic                    addr_in_valid,
  output logic                    addr_in_ready,
  output logic [ADDRESS_SIZE-1:0] mem_addr_out,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  input  logic [DATA_SIZE-1:0]    mem_data_in,
  input  logic                    mem_data_valid,
  output logic [DATA_SIZE-1:0]    data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic [CNT_W-1:0]        inflight,
  output logic                    err
);

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] credits;
  logic             fifo_full, fifo_empty;
  logic             has_credit;
  logic             err_q, err_d;
  lsq_evt_t         evt;

  // Credits come only from registered state, so a pop reopens the request
  // path on the following cycle and no ready->ready path exists.
  assign credits    = inflight_q + fifo_count;
  assign has_credit = (credits < CNT_W'(DEPTH));

  assign mem_addr_out   = addr_in;
  assign mem_req_valid  = rst & addr_in_valid & has_credit;
  assign addr_in_ready  = rst & mem_req_ready & has_credit;
  assign data_out_valid = rst & ~fifo_empty;

  always_comb begin
    evt.fire     = addr_in_valid & addr_in_ready;
    evt.ret      = mem_data_valid & (inflight_q != '0);
    evt.spurious = mem_data_valid & (inflight_q == '0);
    evt.pop      = data_out_valid & data_out_ready;
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({evt.fire, evt.ret})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    err_d = err_q | evt.spurious;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight = inflight_q;
  assign err      = err_q;

  // The credit limit guarantees a free slot for every accepted return; the
  // full guard only keeps a corrupted count from overwriting live data.
  lsq_load_port_data_fifo #(
    .Depth     (DEPTH),
    .DataWidth (DATA_SIZE),
    .CntWidth  (CNT_W)
  ) u_data_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (evt.ret & ~fifo_full),
    .wr_data_i (mem_data_in),
    .rd_en_i   (evt.pop),
    .rd_data_o (data_out),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule
